// File: rtl/counter_mod_k_mode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : counter_mod_k_mode                                                |
// | Brief  : Runtime-modulus up/down counter with wrap/saturate/one-shot modes |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module counter_mod_k_mode #(
  parameter int N = 3,
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic         i_up,
  input  logic [N-1:0] i_k,
  input  logic [1:0]   i_mode,
  input  logic         i_load,
  input  logic [N-1:0] i_load_val,
  output logic [N-1:0] o_count,
  output logic         o_roll_over,
  output logic         o_done,
  output logic [W-1:0] o_wraps
);

  localparam logic [1:0] c_mode_sat     = 2'b01;
  localparam logic [1:0] c_mode_oneshot = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_count;
  logic           r_roll_over;
  logic           r_done;
  logic [W-1:0]   r_wraps;

  logic [N-1:0]   w_top;
  logic           w_out_of_range;
  logic           w_terminal;
  logic [N-1:0]   w_wrap_val;
  logic [N-1:0]   w_term_val;
  logic [N-1:0]   w_step_val;
  logic [N-1:0]   w_load_val;
  logic [W-1:0]   w_wraps_next;

  // K-1 in N bits; k==0 underflows to all-ones, which is exactly 2^N-1.
  always_comb begin
    w_top          = i_k - 1'b1;
    w_out_of_range = (i_k != '0) && (r_count >= i_k);
    w_terminal     = w_out_of_range || (i_up ? (r_count == w_top) : (r_count == '0));
    w_wrap_val     = i_up ? '0 : w_top;
    w_term_val     = i_up ? w_top : '0;
    w_step_val     = i_up ? (r_count + 1'b1) : (r_count - 1'b1);
    w_load_val     = ((i_k == '0) || (i_load_val < i_k)) ? i_load_val : '0;
    w_wraps_next   = (r_wraps == '1) ? r_wraps : (r_wraps + 1'b1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_count     <= '0;
      r_roll_over <= 1'b0;
      r_done      <= 1'b0;
      r_wraps     <= '0;
    end else if (i_load) begin
      r_state     <= ST_RUN;
      r_count     <= w_load_val;
      r_roll_over <= 1'b0;
      r_done      <= 1'b0;
      r_wraps     <= '0;
    end else begin
      r_roll_over <= 1'b0;
      if ((r_state == ST_RUN) && i_en) begin
        if (w_terminal) begin
          r_roll_over <= 1'b1;
          r_wraps     <= w_wraps_next;
          case (i_mode)
            c_mode_sat: begin
              r_count <= w_term_val;
              r_state <= ST_HOLD;
              r_done  <= 1'b1;
            end
            c_mode_oneshot: begin
              r_count <= w_wrap_val;
              r_state <= ST_HOLD;
              r_done  <= 1'b1;
            end
            default: begin
              r_count <= w_wrap_val;
            end
          endcase
        end else begin
          r_count <= w_step_val;
        end
      end
    end
  end

  assign o_count     = r_count;
  assign o_roll_over = r_roll_over;
  assign o_done      = r_done;
  assign o_wraps     = r_wraps;

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_k_mode.sv
`default_nettype none
// Bench for counter_mod_k_mode: integer reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_counter_mod_k_mode;

  localparam int N = 3;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, en, up, load;
  logic [N-1:0] k, load_val;
  logic [1:0]   mode;
  logic [N-1:0] count;
  logic         roll_over, done;
  logic [W-1:0] wraps;

  int checks   = 0;
  int failures = 0;

  // Reference model state (integers, updated on each rising edge)
  int m_cnt   = 0;
  int m_wraps = 0;
  bit m_hold  = 0;
  bit m_roll  = 0;
  bit m_valid = 0;

  counter_mod_k_mode #(.N(N), .W(W)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_en       (en),
    .i_up       (up),
    .i_k        (k),
    .i_mode     (mode),
    .i_load     (load),
    .i_load_val (load_val),
    .o_count    (count),
    .o_roll_over(roll_over),
    .o_done     (done),
    .o_wraps    (wraps)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin : model
    int  keff, c, w;
    bit  h, r, term;
    keff = (k == 0) ? (1 << N) : int'(k);
    c = m_cnt; w = m_wraps; h = m_hold; r = 0;
    if (reset) begin
      c = 0; w = 0; h = 0;
    end else if (load) begin
      c = (int'(load_val) < keff) ? int'(load_val) : 0;
      w = 0; h = 0;
    end else if (!h && en) begin
      term = up ? (c >= keff - 1) : (c == 0 || c >= keff);
      if (term) begin
        r = 1;
        w = (w + 1 > (1 << W) - 1) ? (1 << W) - 1 : w + 1;
        if (mode == 2'd1) begin
          c = up ? keff - 1 : 0; h = 1;
        end else begin
          c = up ? 0 : keff - 1;
          if (mode == 2'd2) h = 1;
        end
      end else begin
        c = up ? c + 1 : c - 1;
      end
    end
    m_cnt   <= c;
    m_wraps <= w;
    m_hold  <= h;
    m_roll  <= r;
    if (reset) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (int'(count) != m_cnt || roll_over != m_roll || done != m_hold || int'(wraps) != m_wraps) begin
        failures++;
        $display("FAIL model t=%0t got count=%0d roll=%0b done=%0b wraps=%0d exp count=%0d roll=%0b done=%0b wraps=%0d",
                 $time, count, roll_over, done, wraps, m_cnt, m_roll, m_hold, m_wraps);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Drive one cycle of inputs; returns once the resulting edge's outputs are stable.
  task automatic apply(input bit rs, input bit ld, input int lv, input bit e,
                       input bit u, input int kk, input int md);
    reset = rs; load = ld; load_val = lv[N-1:0]; en = e; up = u;
    k = kk[N-1:0]; mode = md[1:0];
    @(negedge clk);
  endtask

  int e32c[6] = '{1, 2, 0, 1, 2, 0};
  int e32r[6] = '{0, 0, 1, 0, 0, 1};
  int e33c[6] = '{4, 3, 2, 1, 0, 4};
  int e33r[6] = '{1, 0, 0, 0, 0, 1};
  int e34c[5] = '{1, 2, 3, 3, 3};
  int e34r[5] = '{0, 0, 0, 1, 0};
  int e34d[5] = '{0, 0, 0, 1, 1};

  initial begin
    reset = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1; k = '0; mode = '0;
    @(negedge clk);

    apply(1, 1, 5, 1, 1, 3, 0);
    chk("reset_count", count, 0);
    chk("reset_roll", roll_over, 0);
    chk("reset_done", done, 0);
    chk("reset_wraps", wraps, 0);

    // k=3 wrap up
    for (int i = 0; i < 6; i++) begin
      apply(0, 0, 0, 1, 1, 3, 0);
      chk($sformatf("k3_up_count[%0d]", i), count, e32c[i]);
      chk($sformatf("k3_up_roll[%0d]", i), roll_over, e32r[i]);
    end
    chk("k3_up_wraps", wraps, 2);

    // k=5 wrap down from load 0
    apply(0, 1, 0, 1, 0, 5, 0);
    chk("k5_load_count", count, 0);
    chk("k5_load_wraps", wraps, 0);
    for (int i = 0; i < 6; i++) begin
      apply(0, 0, 0, 1, 0, 5, 0);
      chk($sformatf("k5_dn_count[%0d]", i), count, e33c[i]);
      chk($sformatf("k5_dn_roll[%0d]", i), roll_over, e33r[i]);
    end

    // k=4 saturate up, then reload
    apply(0, 1, 0, 1, 1, 4, 1);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 1, 1, 4, 1);
      chk($sformatf("sat_count[%0d]", i), count, e34c[i]);
      chk($sformatf("sat_roll[%0d]", i), roll_over, e34r[i]);
      chk($sformatf("sat_done[%0d]", i), done, e34d[i]);
    end
    apply(0, 1, 1, 1, 1, 4, 1);
    chk("sat_reload_count", count, 1);
    chk("sat_reload_done", done, 0);
    chk("sat_reload_wraps", wraps, 0);

    // k=0 (8) one-shot up, then frozen while inputs wiggle
    apply(0, 1, 0, 0, 1, 0, 2);
    for (int i = 1; i <= 8; i++) begin
      apply(0, 0, 0, 1, 1, 0, 2);
      chk($sformatf("os_count[%0d]", i), count, i % 8);
      chk($sformatf("os_roll[%0d]", i), roll_over, (i == 8) ? 1 : 0);
    end
    chk("os_done", done, 1);
    chk("os_wraps", wraps, 1);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 1, i[0], 3, 0);
      chk($sformatf("os_hold_count[%0d]", i), count, 0);
      chk($sformatf("os_hold_roll[%0d]", i), roll_over, 0);
      chk($sformatf("os_hold_wraps[%0d]", i), wraps, 1);
    end

    // k shrinks below current count
    apply(0, 1, 6, 0, 1, 7, 0);
    chk("shrink_load6", count, 6);
    apply(0, 0, 0, 1, 1, 4, 0);
    chk("shrink_count", count, 0);
    chk("shrink_roll", roll_over, 1);
    apply(0, 1, 6, 0, 1, 4, 0);
    chk("load_oob_count", count, 0);
    apply(0, 1, 6, 0, 1, 7, 0);
    apply(0, 0, 0, 1, 0, 4, 0);
    chk("shrink_dn_count", count, 3);
    chk("shrink_dn_roll", roll_over, 1);
    apply(0, 1, 6, 0, 1, 7, 1);
    apply(0, 0, 0, 1, 0, 4, 1);
    chk("shrink_sat_dn_count", count, 0);
    chk("shrink_sat_dn_done", done, 1);

    // reset beats load mid-run; enable low freezes
    apply(0, 1, 0, 1, 1, 7, 0);
    apply(0, 0, 0, 1, 1, 7, 0);
    apply(0, 0, 0, 1, 1, 7, 0);
    chk("pre_rst_count", count, 2);
    apply(1, 1, 5, 1, 1, 7, 0);
    chk("rst_ld_count", count, 0);
    chk("rst_ld_wraps", wraps, 0);
    chk("rst_ld_roll", roll_over, 0);
    apply(0, 0, 0, 1, 1, 7, 0);
    apply(0, 0, 0, 1, 1, 7, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, i[0], 7, 0);
      chk($sformatf("en0_count[%0d]", i), count, 2);
      chk($sformatf("en0_roll[%0d]", i), roll_over, 0);
    end

    // reset out of HOLD
    apply(0, 1, 0, 1, 1, 1, 1);
    apply(0, 0, 0, 1, 1, 1, 1);
    chk("k1_sat_done", done, 1);
    apply(1, 0, 0, 1, 1, 1, 1);
    chk("hold_rst_done", done, 0);

    // K=1 wrap (mode 11): pulse every cycle, wrap counter saturates
    apply(0, 1, 0, 1, 1, 1, 3);
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, 0, 1, 1, 1, 3);
      chk($sformatf("k1_roll[%0d]", i), roll_over, 1);
    end
    chk("k1_count", count, 0);
    chk("k1_wraps_sat", wraps, 15);

    // Mixed stimulus checked by the model alone
    for (int i = 0; i < 150; i++) begin
      apply($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_mod_k_mode.md
COUNTER_MOD_K_MODE -- requirements
Module: counter_mod_k_mode

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning counter and modulus width in bits.
REQ-002 The block SHALL have parameter W, default 4, meaning wrap-event counter width in bits.
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port i_en, input, 1, count enable.
REQ-006 The block SHALL have port i_up, input, 1, direction: 1 counts up, 0 counts down.
REQ-007 The block SHALL have port i_k, input, N, the runtime modulus; 0 means 2^N.
REQ-008 The block SHALL have port i_mode, input, 2, where 00 = wrap, 01 = saturate, 10 = one-shot, and 11 behaves as wrap.
REQ-009 The block SHALL have port i_load, input, 1, synchronous load strobe.
REQ-010 The block SHALL have port i_load_val, input, N, the load value.
REQ-011 The block SHALL have port o_count, output, N, the current count (register).
REQ-012 The block SHALL have port o_roll_over, output, 1, a registered one-cycle terminal-event pulse.
REQ-013 The block SHALL have port o_done, output, 1, a registered flag, high in state HOLD.
REQ-014 The block SHALL have port o_wraps, output, W, a saturating count of terminal events since reset or load.

Function
REQ-015 Let K_eff = (i_k == 0) ? 2^N : i_k; count range SHALL be 0..K_eff-1, terminal value T = K_eff-1 when counting up and 0 when counting down.
REQ-016 The FSM SHALL have states RUN and HOLD; reset enters RUN.
REQ-017 Priority per edge SHALL be: reset > load > enable step > idle hold.
REQ-018 On i_load, o_count SHALL take i_load_val if i_load_val < K_eff, else 0; FSM goes to RUN; o_wraps clears; o_roll_over stays 0 that cycle.
REQ-019 In RUN with i_en=1 and count != T, count SHALL step by +1 (up) or -1 (down) with no pulse.
REQ-020 In RUN with i_en=1 and count == T (terminal event), wrap mode SHALL go to 0 (up) or K_eff-1 (down), pulse o_roll_over for exactly the next cycle, and increment o_wraps.
REQ-021 On a terminal event, saturate mode SHALL hold count at T, pulse o_roll_over once, increment o_wraps, and enter HOLD.
REQ-022 On a terminal event, one-shot mode SHALL wrap as in REQ-020, pulse o_roll_over, increment o_wraps, and enter HOLD.
REQ-023 In HOLD, count and o_wraps SHALL be frozen regardless of i_en, i_up or i_k; exit only via i_load or reset.
REQ-024 With i_en=0, all state SHALL hold; o_roll_over SHALL be 0.
REQ-025 If count >= K_eff (after i_k shrinks), the next enabled step SHALL be treated as a terminal event.
REQ-026 K_eff = 1 SHALL give count fixed at 0 with a terminal event on every enabled RUN cycle.
REQ-027 o_wraps SHALL saturate at 2^W-1, never wrapping.
REQ-028 Changing i_up or i_mode mid-count SHALL take effect on the next edge with no glitch on outputs.
REQ-029 Latency: outputs SHALL reflect inputs sampled at edge n after edge n, i.e. one clock; there SHALL be no combinational input-to-output path.

Reset
REQ-030 When i_reset=1 at an edge: o_count=0, o_roll_over=0, o_done=0, o_wraps=0, FSM=RUN; i_reset SHALL override i_load and i_en in the same cycle.
REQ-031 Reset asserted mid-count or in HOLD SHALL produce the same state as REQ-030 after one edge.

Verification
REQ-032 N=3, k=3, wrap, up, en=1 after reset: count SHALL go 0,1,2,0,1,2,0; o_roll_over SHALL be high only in the cycles showing the returned 0; o_wraps 2 after 6 steps.
REQ-033 k=5, down, wrap, starting from load 0: count SHALL go 0,4,3,2,1,0,4; a pulse SHALL occur with each 4 that follows 0.
REQ-034 k=4, saturate, up: count SHALL go 0,1,2,3,3,3; one pulse; o_done=1 from the cycle after reaching 3; load 1 SHALL give count=1, o_done=0, o_wraps=0.
REQ-035 k=0 (2^3), one-shot, up: count SHALL run 0..7 then 0, one pulse, o_done=1, count frozen at 0 while en=1.
REQ-036 Count at 6 with k=7, then k changed to 4: the next enabled edge SHALL give count=0 with a pulse; load_val=6 with k=4 SHALL load 0.
REQ-037 Reset and load asserted together mid-run at count 2: the result SHALL be count=0, o_wraps=0, no pulse; i_en=0 for 3 cycles SHALL freeze count.
